// File: rtl/systolic_feeder_pkg.sv
// Shared types for the systolic feeder: controller states, default data width, len width helper.
package systolic_feeder_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // Width able to hold any count 0..depth inclusive.
  function automatic int len_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/systolic_feeder_fifo.sv
// Synchronous FIFO for activation vectors; head is read combinationally, push/pop take effect at the edge.
// Pop-while-full does not open a slot the same cycle: full_o depends only on the registered count.
module feeder_fifo #(
  parameter  int W     = 32,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [W-1:0]     wdata_i,
  input  logic             pop_i,
  output logic [W-1:0]     rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/systolic_feeder.sv
// Feeds a 2x2 systolic array: loads PE weights, then streams queued {x0,x1} vectors with row 1 skewed by one cycle.
// First valid output 1 cycle after the start edge; in_ready drops only when the FIFO is full.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter  int DATA_W       = DATA_W_DEF,
  parameter  int DEPTH        = 8,
  parameter  int DRAIN_CYCLES = 2,
  localparam int LEN_W        = len_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x0,
  input  logic [DATA_W-1:0] in_x1,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_in1,
  input  logic [DATA_W-1:0] w_in2,
  input  logic [DATA_W-1:0] w_in3,
  input  logic [DATA_W-1:0] w_in4,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              start_err,
  output logic              load_weight,
  output logic              valid,
  output logic [DATA_W-1:0] a_in1,
  output logic [DATA_W-1:0] a_in2,
  output logic [DATA_W-1:0] weight1,
  output logic [DATA_W-1:0] weight2,
  output logic [DATA_W-1:0] weight3,
  output logic [DATA_W-1:0] weight4
);

  localparam int DRN_W = $clog2(DRAIN_CYCLES + 2);
  localparam int CTR_W = (LEN_W > DRN_W) ? LEN_W : DRN_W;

  state_t              state_q;
  logic [CTR_W-1:0]    ctr_q;
  logic                w_loaded_q;
  logic [DATA_W-1:0]   weight1_q, weight2_q, weight3_q, weight4_q;
  logic                load_weight_q, valid_q, done_q, start_err_q;
  logic [DATA_W-1:0]   a_in1_q, a_in2_q, skew_q;

  logic                fifo_full;
  logic                fifo_push, fifo_pop;
  logic [LEN_W-1:0]    fifo_count;
  logic [2*DATA_W-1:0] fifo_rdata;
  logic                start_ok;

  assign fifo_push = in_valid & ~fifo_full;
  assign fifo_pop  = (state_q == ST_STREAM);
  assign start_ok  = w_loaded_q && (len != '0) && (fifo_count >= len);

  feeder_fifo #(
    .W     (2 * DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (fifo_push),
    .wdata_i ({in_x1, in_x0}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      ctr_q         <= '0;
      w_loaded_q    <= 1'b0;
      weight1_q     <= '0;
      weight2_q     <= '0;
      weight3_q     <= '0;
      weight4_q     <= '0;
      load_weight_q <= 1'b0;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
      start_err_q   <= 1'b0;
      a_in1_q       <= '0;
      a_in2_q       <= '0;
      skew_q        <= '0;
    end else begin
      load_weight_q <= 1'b0;
      done_q        <= 1'b0;
      start_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A weight load shadows a simultaneous start without flagging an error.
          if (w_valid) begin
            weight1_q     <= w_in1;
            weight2_q     <= w_in2;
            weight3_q     <= w_in3;
            weight4_q     <= w_in4;
            load_weight_q <= 1'b1;
            state_q       <= ST_LOAD_W;
          end else if (start) begin
            if (start_ok) begin
              ctr_q   <= CTR_W'(len);
              state_q <= ST_STREAM;
            end else begin
              start_err_q <= 1'b1;
            end
          end
        end
        ST_LOAD_W: begin
          w_loaded_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
        ST_STREAM: begin
          valid_q <= 1'b1;
          a_in1_q <= fifo_rdata[DATA_W-1:0];
          a_in2_q <= skew_q;
          skew_q  <= fifo_rdata[2*DATA_W-1:DATA_W];
          if (ctr_q == CTR_W'(1)) begin
            ctr_q   <= CTR_W'(DRAIN_CYCLES + 1);
            state_q <= ST_DRAIN;
          end else begin
            ctr_q <= ctr_q - CTR_W'(1);
          end
        end
        ST_DRAIN: begin
          // First drain cycle still flushes the last skewed row-1 element.
          a_in1_q <= '0;
          a_in2_q <= skew_q;
          skew_q  <= '0;
          if (ctr_q != '0) begin
            valid_q <= 1'b1;
            ctr_q   <= ctr_q - CTR_W'(1);
          end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = ~fifo_full;
  assign w_ready     = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign start_err   = start_err_q;
  assign load_weight = load_weight_q;
  assign valid       = valid_q;
  assign a_in1       = a_in1_q;
  assign a_in2       = a_in2_q;
  assign weight1     = weight1_q;
  assign weight2     = weight2_q;
  assign weight3     = weight3_q;
  assign weight4     = weight4_q;

endmodule
